// File: rtl/window_compositor.sv
// window_compositor: maps the VGA raster into N_LAYERS upscaled game windows and
// composites the renderer pixels by fixed priority with a transparency key.
module window_compositor #(
  parameter int          H_VISIBLE_AREA  = 640,
  parameter int          V_VISIBLE_AREA  = 480,
  parameter int          H_ADDR_WIDTH    = 10,
  parameter int          V_ADDR_WIDTH    = 10,
  parameter int          N_LAYERS        = 2,
  parameter int          WIN_W           = 224,
  parameter int          WIN_H           = 288,
  parameter int          SCALE           = 1,
  parameter int          LAYER_LATENCY   = 2,
  parameter logic [11:0] TRANSPARENT_KEY = 12'hF0F,
  parameter logic [11:0] BG_COLOR        = 12'h000,
  localparam int         CLW             = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1,
  localparam int         LW              = $clog2(WIN_W),
  localparam int         LH              = $clog2(WIN_H)
) (
  input  logic                       vga_pix_clk,
  input  logic                       rst_n,
  input  logic [H_ADDR_WIDTH-1:0]    sx,
  input  logic [V_ADDR_WIDTH-1:0]    sy,
  input  logic                       display_enabled,
  input  logic                       frame_stb,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [CLW-1:0]             cfg_layer,
  input  logic [H_ADDR_WIDTH-1:0]    cfg_x_off,
  input  logic [V_ADDR_WIDTH-1:0]    cfg_y_off,
  input  logic                       cfg_en,
  output logic [N_LAYERS*LW-1:0]     layer_sx,
  output logic [N_LAYERS*LH-1:0]     layer_sy,
  output logic [N_LAYERS-1:0]        layer_active,
  input  logic [N_LAYERS*12-1:0]     layer_rgb,
  output logic [3:0]                 R,
  output logic [3:0]                 G,
  output logic [3:0]                 B,
  output logic                       de_out,
  output logic                       frame_stb_out
);
  localparam int LL = LAYER_LATENCY;
  localparam int SH = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
  localparam logic [H_ADDR_WIDTH:0]   W_SPAN = (H_ADDR_WIDTH+1)'(WIN_W * SCALE);
  localparam logic [V_ADDR_WIDTH:0]   H_SPAN = (V_ADDR_WIDTH+1)'(WIN_H * SCALE);
  localparam logic [H_ADDR_WIDTH-1:0] X_RST  = H_ADDR_WIDTH'((H_VISIBLE_AREA - WIN_W * SCALE) / 2);
  localparam logic [V_ADDR_WIDTH-1:0] Y_RST  = V_ADDR_WIDTH'((V_VISIBLE_AREA - WIN_H * SCALE) / 2);

  typedef struct packed {
    logic [H_ADDR_WIDTH-1:0] x_off;
    logic [V_ADDR_WIDTH-1:0] y_off;
    logic                    en;
  } win_t;

  typedef struct packed {
    logic [N_LAYERS-1:0] act;
    logic                de;
    logic                fs;
  } tag_t;

  logic                          rdy_q;
  logic                          wr;
  logic [N_LAYERS-1:0]           hit;
  logic [N_LAYERS-1:0][LW-1:0]   lsx_d, lsx_q;
  logic [N_LAYERS-1:0][LH-1:0]   lsy_d, lsy_q;
  logic [N_LAYERS-1:0][11:0]     lrgb;
  tag_t                          vld_pipe_q [0:LL];
  logic [11:0]                   rgb_d, rgb_q;
  logic                          de_q, fs_q;

  // Config is refused only while shadows are being committed.
  assign cfg_ready = rdy_q & ~frame_stb;
  assign wr        = cfg_valid & cfg_ready;
  assign lrgb      = layer_rgb;

  for (genvar g = 0; g < N_LAYERS; g++) begin : g_layer
    localparam win_t RST = '{x_off: X_RST, y_off: Y_RST, en: (g == 0)};
    win_t                  shd_q, win_q;
    logic [H_ADDR_WIDTH:0] xs, xo, xe, dx;
    logic [V_ADDR_WIDTH:0] ys, yo, ye, dy;

    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
      if (!rst_n) begin
        shd_q <= RST;
        win_q <= RST;
      end else if (frame_stb) begin
        win_q <= shd_q;
      end else if (wr && cfg_layer == CLW'(g)) begin
        shd_q <= '{x_off: cfg_x_off, y_off: cfg_y_off, en: cfg_en};
      end
    end

    // One extra bit so a window end past the address range cannot wrap.
    assign xs = {1'b0, sx};
    assign ys = {1'b0, sy};
    assign xo = {1'b0, win_q.x_off};
    assign yo = {1'b0, win_q.y_off};
    assign xe = xo + W_SPAN;
    assign ye = yo + H_SPAN;
    assign dx = xs - xo;
    assign dy = ys - yo;

    assign hit[g]   = win_q.en && display_enabled && (xs >= xo) && (xs < xe)
                      && (ys >= yo) && (ys < ye);
    assign lsx_d[g] = hit[g] ? LW'(dx >> SH) : '0;
    assign lsy_d[g] = hit[g] ? LH'(dy >> SH) : '0;
  end

  always_comb begin
    rgb_d = BG_COLOR;
    for (int i = N_LAYERS - 1; i >= 0; i--)
      if (vld_pipe_q[LL].act[i] && lrgb[i] != TRANSPARENT_KEY) rgb_d = lrgb[i];
    if (!vld_pipe_q[LL].de) rgb_d = '0;
  end

  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      lsx_q <= '0;
      lsy_q <= '0;
      for (int k = 0; k <= LL; k++) vld_pipe_q[k] <= '0;
      rgb_q <= '0;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      rdy_q         <= 1'b1;
      lsx_q         <= lsx_d;
      lsy_q         <= lsy_d;
      vld_pipe_q[0] <= '{act: hit, de: display_enabled, fs: frame_stb};
      for (int k = 1; k <= LL; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
      rgb_q         <= rgb_d;
      de_q          <= vld_pipe_q[LL].de;
      fs_q          <= vld_pipe_q[LL].fs;
    end
  end

  assign layer_sx      = lsx_q;
  assign layer_sy      = lsy_q;
  assign layer_active  = vld_pipe_q[0].act;
  assign {R, G, B}     = rgb_q;
  assign de_out        = de_q;
  assign frame_stb_out = fs_q;

endmodule

// File: tb/tb_window_compositor.sv
// Bench for window_compositor: directed vector tables and corner sequences plus
// randomized traffic scored against a cycle-level behavioural model.
module tb_window_compositor;
  localparam int N = 2, LL = 2, LW = 8, LH = 9, LH2 = 8;
  localparam int WW = 224, WH = 288;
  localparam logic [11:0] KEY = 12'hF0F;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] sx = '0, sy = '0, cfg_x = '0, cfg_y = '0;
  logic de = 1'b0, fstb = 1'b0, cfg_valid = 1'b0, cfg_en = 1'b0, cfg_layer = 1'b0;
  logic cfg_ready, de_o, fs_o;
  logic [N*LW-1:0] lsx;
  logic [N*LH-1:0] lsy;
  logic [N-1:0] lact;
  logic [N*12-1:0] lrgb = {KEY, KEY};
  logic [3:0] R, G, B;

  logic cfg_valid2 = 1'b0, cfg_layer2 = 1'b0, cfg_ready2, lact2, de2, fs2;
  logic [7:0] lsx2;
  logic [LH2-1:0] lsy2;
  logic [11:0] lrgb2 = 12'h123;
  logic [3:0] R2, G2, B2;

  window_compositor dut (
    .vga_pix_clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy), .display_enabled(de),
    .frame_stb(fstb), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_x_off(cfg_x), .cfg_y_off(cfg_y), .cfg_en(cfg_en), .layer_sx(lsx), .layer_sy(lsy),
    .layer_active(lact), .layer_rgb(lrgb), .R(R), .G(G), .B(B), .de_out(de_o),
    .frame_stb_out(fs_o));

  window_compositor #(.N_LAYERS(1), .SCALE(2), .WIN_H(240)) dut2 (
    .vga_pix_clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy), .display_enabled(de),
    .frame_stb(fstb), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2), .cfg_layer(cfg_layer2),
    .cfg_x_off(cfg_x), .cfg_y_off(cfg_y), .cfg_en(cfg_en), .layer_sx(lsx2), .layer_sy(lsy2),
    .layer_active(lact2), .layer_rgb(lrgb2), .R(R2), .G(G2), .B(B2), .de_out(de2),
    .frame_stb_out(fs2));

  int pass_cnt = 0, tot = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    tot++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Behavioural model: shadow/active offsets and a queue of per-pixel tags.
  typedef struct { bit [N-1:0] act; bit de; bit fs; } ent_t;
  int m_xs[N], m_ys[N], m_xa[N], m_ya[N];
  bit m_es[N], m_ea[N];
  bit m_rdy;
  ent_t hq[$];
  logic [N-1:0] e_act;
  logic [N*LW-1:0] e_lsx;
  logic [N*LH-1:0] e_lsy;
  logic [11:0] e_rgb;
  logic e_de, e_fs;

  task automatic model_reset();
    ent_t z;
    z = '{act: '0, de: 1'b0, fs: 1'b0};
    for (int i = 0; i < N; i++) begin
      m_xs[i] = (640 - WW) / 2; m_ys[i] = (480 - WH) / 2;
      m_xa[i] = m_xs[i];        m_ya[i] = m_ys[i];
      m_es[i] = (i == 0);       m_ea[i] = (i == 0);
    end
    m_rdy = 1'b0;
    hq.delete();
    for (int k = 0; k <= LL; k++) hq.push_back(z);
    e_act = '0; e_lsx = '0; e_lsy = '0; e_rgb = '0; e_de = 1'b0; e_fs = 1'b0;
  endtask

  task automatic model_edge();
    ent_t o, n;
    bit found, h;
    int x, y;
    logic [11:0] px;
    o = hq.pop_front();
    e_de = o.de; e_fs = o.fs;
    e_rgb = 12'h000;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      px = lrgb[i*12 +: 12];
      if (!found && o.act[i] && px != KEY) begin e_rgb = px; found = 1'b1; end
    end
    if (!o.de) e_rgb = 12'h000;
    x = int'(sx); y = int'(sy);
    for (int i = 0; i < N; i++) begin
      h = m_ea[i] && de && x >= m_xa[i] && x < m_xa[i] + WW && y >= m_ya[i] && y < m_ya[i] + WH;
      e_act[i] = h;
      e_lsx[i*LW +: LW] = h ? LW'(x - m_xa[i]) : '0;
      e_lsy[i*LH +: LH] = h ? LH'(y - m_ya[i]) : '0;
    end
    n = '{act: e_act, de: de, fs: fstb};
    hq.push_back(n);
    if (fstb) begin
      for (int i = 0; i < N; i++) begin m_xa[i] = m_xs[i]; m_ya[i] = m_ys[i]; m_ea[i] = m_es[i]; end
    end else if (cfg_valid && m_rdy && int'(cfg_layer) < N) begin
      m_xs[cfg_layer] = int'(cfg_x); m_ys[cfg_layer] = int'(cfg_y); m_es[cfg_layer] = cfg_en;
    end
    m_rdy = 1'b1;
  endtask

  task automatic model_check();
    check("model_stage1", {lact, lsx, lsy}, {e_act, e_lsx, e_lsy});
    check("model_out", {R, G, B, de_o, fs_o}, {e_rgb, e_de, e_fs});
    check("model_cfg_ready", 64'(cfg_ready), 64'(m_rdy && !fstb));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    if (rst_n) model_check();
  endtask

  task automatic cfg_write(bit l, int x, int y, bit en);
    cfg_valid = 1'b1; cfg_layer = l; cfg_x = 10'(x); cfg_y = 10'(y); cfg_en = en;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic commit();
    fstb = 1'b1; tick(); fstb = 1'b0;
  endtask

  typedef struct { int sx; int sy; bit de; bit [1:0] act; int lsx0; int lsy0; } vec_t;
  typedef struct { int sx; bit de; bit a; int l; } clip_t;
  vec_t  vt[8];
  clip_t ct[7];

  initial begin
    vt[0] = '{208, 96, 1'b1, 2'b01, 0, 0};
    vt[1] = '{431, 96, 1'b1, 2'b01, 223, 0};
    vt[2] = '{432, 96, 1'b1, 2'b00, 0, 0};
    vt[3] = '{207, 96, 1'b1, 2'b00, 0, 0};
    vt[4] = '{208, 383, 1'b1, 2'b01, 0, 287};
    vt[5] = '{208, 384, 1'b1, 2'b00, 0, 0};
    vt[6] = '{300, 200, 1'b0, 2'b00, 0, 0};
    vt[7] = '{300, 200, 1'b1, 2'b01, 92, 104};
    ct[0] = '{600, 1'b1, 1'b1, 0};
    ct[1] = '{639, 1'b1, 1'b1, 39};
    ct[2] = '{599, 1'b1, 1'b0, 0};
    ct[3] = '{0, 1'b1, 1'b0, 0};
    ct[4] = '{100, 1'b1, 1'b0, 0};
    ct[5] = '{183, 1'b1, 1'b0, 0};
    ct[6] = '{640, 1'b0, 1'b0, 0};

    model_reset();
    repeat (2) tick();
    check("reset_outputs", {lact, lsx, lsy, R, G, B, de_o, fs_o}, 64'd0);
    rst_n = 1'b1;
    de = 1'b1;
    tick();

    // Stage-1 vectors under the reset configuration.
    foreach (vt[i]) begin
      sx = 10'(vt[i].sx); sy = 10'(vt[i].sy); de = vt[i].de;
      tick();
      check("tbl_act", 64'(lact), 64'(vt[i].act));
      check("tbl_lsx0", 64'(lsx[LW-1:0]), 64'(vt[i].lsx0));
      check("tbl_lsy0", 64'(lsy[LH-1:0]), 64'(vt[i].lsy0));
    end

    // One hit pixel surfaces exactly four cycles later.
    de = 1'b1; lrgb = {12'h0F0, 12'h00F}; sx = 10'd0; sy = 10'd96;
    repeat (5) tick();
    sx = 10'd208; tick();
    sx = 10'd0;   tick();
    tick(); check("lat_early", {R, G, B}, 12'h000);
    tick(); check("lat_hit", {R, G, B, de_o}, {12'h00F, 1'b1});
    tick(); check("lat_after", {R, G, B}, 12'h000);

    // Priority and transparency.
    cfg_write(1'b1, 208, 96, 1'b1);
    commit();
    sx = 10'd208; sy = 10'd96; lrgb = {12'h0F0, KEY};
    repeat (4) tick();
    check("prio_act", 64'(lact), 64'd3);
    check("prio_l1", {R, G, B}, 12'h0F0);
    lrgb = {12'h0F0, 12'h00F}; tick();
    check("prio_l0", {R, G, B}, 12'h00F);
    lrgb = {KEY, KEY}; tick();
    check("prio_bg", {R, G, B}, 12'h000);

    // Shadowed config commits only at frame_stb.
    cfg_valid = 1'b1; cfg_layer = 1'b0; cfg_x = 10'd0; cfg_y = 10'd96; cfg_en = 1'b1;
    #1 check("shd_rdy", 64'(cfg_ready), 64'd1);
    tick(); cfg_valid = 1'b0;
    sx = 10'd0; tick();
    check("shd_hold", 64'(lact[0]), 64'd0);
    sx = 10'd208; tick();
    check("shd_old", {lact[0], lsx[LW-1:0]}, {1'b1, 8'd0});
    fstb = 1'b1; cfg_valid = 1'b1; cfg_layer = 1'b1; cfg_x = 10'd5; cfg_en = 1'b1; sx = 10'd0;
    #1 check("shd_fstb_rdy", 64'(cfg_ready), 64'd0);
    tick();
    check("shd_fstb_pix", 64'(lact[0]), 64'd0);
    fstb = 1'b0;
    #1 check("shd_retry_rdy", 64'(cfg_ready), 64'd1);
    tick(); cfg_valid = 1'b0;
    tick();
    check("shd_new", {lact[0], lsx[LW-1:0]}, {1'b1, 8'd0});
    sx = 10'd5; tick();
    check("shd_l1_pending", 64'(lact[1]), 64'd0);
    commit(); tick();
    check("shd_l1_new", {lact[1], lsx[2*LW-1:LW]}, {1'b1, 8'd0});

    // Right-edge clipping.
    cfg_write(1'b0, 600, 96, 1'b1);
    cfg_write(1'b1, 0, 0, 1'b0);
    commit();
    sy = 10'd100;
    foreach (ct[i]) begin
      sx = 10'(ct[i].sx); de = ct[i].de; tick();
      check("clip", {lact[0], lsx[LW-1:0]}, {ct[i].a, 8'(ct[i].l)});
    end

    // SCALE=2 instance, plus a discarded out-of-range write.
    de = 1'b1; sy = 10'd0;
    for (int k = 0; k < 4; k++) begin
      sx = 10'(96 + k); tick();
      check("s2_lsx", {lact2, lsx2}, {1'b1, 8'(k / 2)});
    end
    sx = 10'd543; tick(); check("s2_last", {lact2, lsx2}, {1'b1, 8'd223});
    sx = 10'd544; tick(); check("s2_past", 64'(lact2), 64'd0);
    cfg_valid2 = 1'b1; cfg_layer2 = 1'b1; cfg_x = 10'd0; cfg_y = 10'd0; cfg_en = 1'b1;
    tick(); cfg_valid2 = 1'b0;
    commit();
    sx = 10'd0;  tick(); check("s2_oor_x0", 64'(lact2), 64'd0);
    sx = 10'd96; tick(); check("s2_oor_keep", {lact2, lsx2}, {1'b1, 8'd0});

    // Asynchronous reset mid-line, then recovery.
    sx = 10'd620; sy = 10'd100; lrgb = {12'h0F0, 12'h00F};
    repeat (5) tick();
    check("pre_rst_out", {R, G, B}, 12'h00F);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {lact, lsx, lsy, R, G, B, de_o, fs_o}, 64'd0);
    model_reset();
    @(negedge clk);
    tick();
    rst_n = 1'b1; sx = 10'd300; sy = 10'd200;
    tick(); tick(); tick();
    check("rst_black", {R, G, B}, 12'h000);
    tick();
    check("rst_resume", {R, G, B}, 12'h00F);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      sx = ($urandom % 2) ? 10'($urandom_range(150, 700)) : 10'($urandom);
      sy = ($urandom % 2) ? 10'($urandom_range(50, 450)) : 10'($urandom);
      de = ($urandom % 8) != 0;
      fstb = ($urandom % 24) == 0;
      cfg_valid = ($urandom % 4) == 0;
      cfg_layer = 1'($urandom);
      cfg_x = 10'($urandom_range(0, 700));
      cfg_y = 10'($urandom_range(0, 400));
      cfg_en = 1'($urandom);
      for (int i = 0; i < N; i++)
        lrgb[i*12 +: 12] = ($urandom % 2) ? KEY : 12'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule

// File: doc/window_compositor.md
# window_compositor

Parametrised successor to the single-window display path: maps the VGA raster into N_LAYERS independently positioned game windows, with integer upscaling. It composites the per-layer pixels returned by the layer renderers, using fixed priority and a transparency key, and emits the final registered RGB. It sits between the VGA timing generator and the pins. Window positions are runtime-programmable through a shadowed config port that commits only on frame boundaries, so there is no tearing.

## Interface

Parameters:
- H_VISIBLE_AREA, 640: visible VGA columns
- V_VISIBLE_AREA, 480: visible VGA rows
- H_ADDR_WIDTH, 10: width of sx
- V_ADDR_WIDTH, 10: width of sy
- N_LAYERS, 2: number of windows; 1..8
- WIN_W, 224: window width in game pixels
- WIN_H, 288: window height in game pixels
- SCALE, 1: screen pixels per game pixel; legal values 1, 2, 4 only
- LAYER_LATENCY, 2: fixed cycles from layer_sx/sy valid to layer_rgb valid
- TRANSPARENT_KEY, 12'hF0F: layer colour treated as see-through
- BG_COLOR, 12'h000: colour where no layer is opaque

Ports:
- vga_pix_clk, in, 1: sole clock
- rst_n, in, 1: reset, asynchronous assert, active-low
- sx, in, H_ADDR_WIDTH: raster column
- sy, in, V_ADDR_WIDTH: raster row
- display_enabled, in, 1: raster in visible area
- frame_stb, in, 1: one-cycle start-of-frame pulse
- cfg_valid, in, 1: config write request
- cfg_ready, out, 1: config write can be accepted
- cfg_layer, in, max(1,$clog2(N_LAYERS)): target layer
- cfg_x_off, in, H_ADDR_WIDTH: window left edge in screen pixels
- cfg_y_off, in, V_ADDR_WIDTH: window top edge in screen pixels
- cfg_en, in, 1: layer enable
- layer_sx, out, N_LAYERS*$clog2(WIN_W): per-layer game column, packed with layer 0 in the LSBs
- layer_sy, out, N_LAYERS*$clog2(WIN_H): per-layer game row
- layer_active, out, N_LAYERS: raster inside an enabled window
- layer_rgb, in, N_LAYERS*12: per-layer {R,G,B}, LAYER_LATENCY after layer_sx
- R, G, B, out, 4 each: composited colour
- de_out, out, 1: display_enabled delayed to align with RGB
- frame_stb_out, out, 1: frame_stb delayed to align with RGB

## Operation

- Each layer has two register sets, shadow and active, each holding {x_off, y_off, en}.
  - A config write (cfg_valid && cfg_ready) updates the shadow set of cfg_layer.
  - If cfg_layer >= N_LAYERS, the write is accepted and discarded.
- On a frame_stb cycle, all shadow sets copy to their active sets.
  - cfg_ready is 0 in that cycle and 1 otherwise.
  - A write held across frame_stb is accepted on the next cycle and takes effect at the following frame.
- Reset values:
  - Every layer's shadow and active x_off = (H_VISIBLE_AREA-WIN_W*SCALE)/2.
  - Every layer's y_off = (V_VISIBLE_AREA-WIN_H*SCALE)/2.
  - en = 1 for layer 0 only.
- Window hit for layer i requires all of:
  - en_i;
  - display_enabled;
  - x_off_i <= sx < x_off_i+WIN_W*SCALE;
  - y_off_i <= sy < y_off_i+WIN_H*SCALE.
- Compare in width H_ADDR_WIDTH+1 (V_ADDR_WIDTH+1 for rows) so that the end coordinate cannot wrap. Windows hanging past the visible edge are clipped by display_enabled.
- Game coordinates: layer_sx_i = (sx-x_off_i) >> log2(SCALE), and likewise for layer_sy_i. When the window is not hit, the coordinates are forced to 0 and layer_active_i = 0.
- Compositing selects the lowest-index layer that was active and whose layer_rgb != TRANSPARENT_KEY.
  - If no layer qualifies, output BG_COLOR.
  - If delayed display_enabled = 0, R/G/B = 0 regardless.

## Timing

- Stage 1: layer_sx, layer_sy and layer_active are registered 1 cycle after sx/sy.
- Layer renderers: layer_rgb is sampled LAYER_LATENCY cycles after stage 1.
  - layer_active and display_enabled travel down a matched delay line and are not recomputed.
- Output stage: R/G/B are registered. Total latency from sx to RGB is L = LAYER_LATENCY+2 cycles.
- de_out and frame_stb_out are delayed by exactly L.
- New active offsets apply from the first pixel after the frame_stb cycle.
- Reset: R/G/B, de_out, frame_stb_out, layer_sx, layer_sy and layer_active are all 0; all delay lines clear; cfg_ready = 1 from the first clock after rst_n deasserts.
- Reset asserted mid-frame clears everything immediately. Output is black until valid data has propagated L cycles after release.

## Test plan

- Defaults, N_LAYERS=2, SCALE=1, LAYER_LATENCY=2: at sx=208,sy=96, layer_active=01 and layer_sx0=0. At sx=431 layer_sx0=223; at sx=432 layer_active0=0. A layer returning 12'h00F appears as B=F exactly 4 cycles after the sx input.
- Priority: enable layer 1 at the same offset, with layer0=12'hF0F and layer1=12'h0F0 → G=F. Layer0=12'h00F → B=F. Both transparent → BG 0.
- Shadowing: write layer 0 x_off=0 mid-frame → no change until frame_stb. The write cycle coincident with frame_stb sees cfg_ready=0. After the next frame_stb, sx=0 gives layer_sx0=0.
- SCALE=2: x_off=96 → layer_sx0 reads 0,0,1,1,… and the last hit is at sx=543 with layer_sx0=223.
- Edge clip: x_off=600, WIN_W=224 → active only for sx 600..639. No wrap hit at sx 0..183.
- Reset pulse mid-line → all outputs 0 asynchronously. Output resumes correct colours L cycles after release.
